latch_sequencer: RTL and testbench
==================================

# latch_sequencer

Multicycle control FSM that sequences the processor's inter-stage latches (instruction, operand, ALU-result, memory-data) and the PC update. Sits between the decode logic and the datapath latch bank; every latch enable in the datapath is driven from this block. Handles the memory ready handshake, watchdogs stalled memory accesses and counts retired instructions.

## Interface
Parameters:
- RETIRE_WIDTH, 16, width of retired-instruction counter
- MEM_TIMEOUT, 255, consecutive not-ready cycles in a memory state before FAULT (legal range 1..255)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- run  input  1  level; permits starting the next instruction
- opClass  input  2  00 ALU, 01 LOAD, 10 STORE, 11 BRANCH; sampled in DECODE
- isHalt  input  1  halt instruction flag; sampled in DECODE
- branchTaken  input  1  sampled in EXECUTE when latched class is BRANCH
- memReady  input  1  memory completes current request this cycle
- memReq  output  1  memory request
- memWrite  output  1  request is a write
- irEnable  output  1  instruction latch enable
- operandEnable  output  1  operand latch enable
- aluOutEnable  output  1  ALU result latch enable
- mdrEnable  output  1  memory-data latch enable
- pcEnable  output  1  PC latch enable
- pcSelBranch  output  1  PC source: 1 branch target, 0 PC+1
- regWrite  output  1  register file write
- state  output  3  current state encoding
- retired  output  RETIRE_WIDTH  retired-instruction count
- fault  output  1  memory timeout occurred

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALTED=6, FAULT=7.
- All outputs not listed for a state are 0. Outputs are combinational from state, latched class and inputs.
- IDLE: run=1 -> FETCH; else stay.
- FETCH: memReq=1, memWrite=0. memReady=1: irEnable=1, pcEnable=1, pcSelBranch=0 same cycle; -> DECODE.
- DECODE: operandEnable=1; opClass registered into internal class register. isHalt=1 -> HALTED (operandEnable still 1); else -> EXECUTE.
- EXECUTE: aluOutEnable=1. Class ALU -> WRITEBACK; LOAD/STORE -> MEMORY; BRANCH: pcEnable=branchTaken, pcSelBranch=branchTaken, instruction retires, -> FETCH if run else IDLE.
- MEMORY: memReq=1, memWrite=1 iff class STORE. On memReady: LOAD -> mdrEnable=1, -> WRITEBACK; STORE -> retires, -> FETCH if run else IDLE.
- WRITEBACK: regWrite=1, retires, -> FETCH if run else IDLE.
- HALTED: terminal until reset. FAULT: fault=1, terminal until reset.
- Retire: retired increments by 1 at the clock edge ending the retiring cycle; wraps 2^RETIRE_WIDTH-1 -> 0. HALT does not retire.
- Watchdog: 8-bit waitCount cleared on entry to FETCH/MEMORY and when memReady=1; increments each FETCH/MEMORY cycle with memReady=0. memReady=0 while waitCount==MEM_TIMEOUT-1 -> FAULT. memReady=1 in that cycle completes normally (ready wins).

## Timing
- Reset (async): state=IDLE, class=ALU, waitCount=0, retired=0, fault=0, all enables/memReq 0 immediately, not waiting for clk.
- Zero-wait-state latency from FETCH entry: BRANCH 3 cycles, ALU 4, STORE 4, LOAD 5; each memory wait cycle adds 1.
- run sampled only at instruction boundary (IDLE or retiring cycle); deasserting run mid-instruction does not abort it.
- memReq held continuously until memReady; request attributes stable while waiting.
- opClass/isHalt only required valid in DECODE cycle; branchTaken only in EXECUTE.
- Reset asserted mid-access drops memReq in the same cycle; no retire counted.
- FAULT cleared only by reset.

## Test plan
- Reset then run=1, opClass=ALU, memReady=1 always -> states 1,2,3,5,1; regWrite pulse 1 cycle in state 5; retired=1 after 4 cycles.
- LOAD with memReady low 3 cycles in MEMORY -> memReq high 4 cycles, memWrite=0, mdrEnable coincides with memReady, retired=1 after 8 cycles.
- BRANCH, branchTaken=1 -> pcEnable and pcSelBranch high in EXECUTE, no regWrite, next state FETCH; branchTaken=0 -> pcEnable 0 in EXECUTE.
- MEM_TIMEOUT=4, memReady held 0 in FETCH -> FAULT after 4 FETCH cycles, fault=1, memReq=0; memReady=1 on 4th cycle -> DECODE instead.
- isHalt=1 in DECODE -> HALTED, retired unchanged, outputs 0 despite run=1; async reset mid-MEMORY -> IDLE, memReq=0 before next edge.
- RETIRE_WIDTH=4, 16 STORE instructions -> retired wraps 15 -> 0; run dropped during instruction 16 -> IDLE after it retires.

Source files
------------

// File: rtl/latch_sequencer.sv
// latch_sequencer: multicycle FSM driving the datapath latch enables and PC update,
// with memory ready handshake, access watchdog and retired-instruction counter.
module latch_sequencer #(
  parameter int RETIRE_WIDTH = 16,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic [1:0]              opClass,
  input  logic                    isHalt,
  input  logic                    branchTaken,
  input  logic                    memReady,
  output logic                    memReq,
  output logic                    memWrite,
  output logic                    irEnable,
  output logic                    operandEnable,
  output logic                    aluOutEnable,
  output logic                    mdrEnable,
  output logic                    pcEnable,
  output logic                    pcSelBranch,
  output logic                    regWrite,
  output logic [2:0]              state,
  output logic [RETIRE_WIDTH-1:0] retired,
  output logic                    fault
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALTED, FAULT} state_t;
  localparam logic [1:0] ALU = 2'b00, LOAD = 2'b01, STORE = 2'b10, BRANCH = 2'b11;
  state_t cur, nxt, nextInstr;
  logic [1:0] opClassQ;
  logic [7:0] waitCount;
  logic inMem, timeout, retire;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cur       <= IDLE;
      opClassQ  <= ALU;
      waitCount <= '0;
      retired   <= '0;
    end else begin
      cur <= nxt;
      if (cur == DECODE) opClassQ <= opClass;
      // outside FETCH/MEMORY the count idles at zero, so every entry starts fresh
      waitCount <= inMem && !memReady ? waitCount + 8'd1 : 8'd0;
      if (retire) retired <= retired + 1'b1;
    end
  always_comb begin
    inMem         = cur == FETCH || cur == MEMORY;
    timeout       = inMem && !memReady && waitCount == 8'(MEM_TIMEOUT - 1);
    nextInstr     = run ? FETCH : IDLE;
    retire        = (cur == EXECUTE && opClassQ == BRANCH) || (cur == MEMORY && opClassQ == STORE && memReady) || cur == WRITEBACK;
    memReq        = inMem;
    memWrite      = cur == MEMORY && opClassQ == STORE;
    irEnable      = cur == FETCH && memReady;
    operandEnable = cur == DECODE;
    aluOutEnable  = cur == EXECUTE;
    mdrEnable     = cur == MEMORY && opClassQ == LOAD && memReady;
    pcSelBranch   = cur == EXECUTE && opClassQ == BRANCH && branchTaken;
    pcEnable      = irEnable || pcSelBranch;
    regWrite      = cur == WRITEBACK;
    fault         = cur == FAULT;
    nxt           = cur;
    case (cur)
      IDLE:      nxt = nextInstr;
      FETCH:     nxt = memReady ? DECODE : timeout ? FAULT : FETCH;
      DECODE:    nxt = isHalt ? HALTED : EXECUTE;
      EXECUTE:   nxt = opClassQ == ALU ? WRITEBACK : opClassQ == BRANCH ? nextInstr : MEMORY;
      MEMORY:    nxt = memReady ? (opClassQ == LOAD ? WRITEBACK : nextInstr) : timeout ? FAULT : MEMORY;
      WRITEBACK: nxt = nextInstr;
      default:   nxt = cur;
    endcase
  end
  assign state = cur;
endmodule

// File: tb/tb_latch_sequencer.sv
// tb_latch_sequencer: directed stimulus with an instruction-level reference model
// compared every cycle, plus hand-computed literal checks.
module tb_latch_sequencer;
  localparam int RW = 4;
  localparam int MT = 4;
  logic clk = 0, reset = 1, run = 0, isHalt = 0, branchTaken = 0, memReady = 0;
  logic [1:0] opClass = 0;
  logic memReq, memWrite, irEnable, operandEnable, aluOutEnable, mdrEnable;
  logic pcEnable, pcSelBranch, regWrite, fault;
  logic [2:0] state;
  logic [RW-1:0] retired;
  int total = 0, bad = 0;
  int mState = 0, mCls = 0, mStall = 0, mRet = 0;

  latch_sequencer #(.RETIRE_WIDTH(RW), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset), .run(run), .opClass(opClass), .isHalt(isHalt),
    .branchTaken(branchTaken), .memReady(memReady), .memReq(memReq), .memWrite(memWrite),
    .irEnable(irEnable), .operandEnable(operandEnable), .aluOutEnable(aluOutEnable),
    .mdrEnable(mdrEnable), .pcEnable(pcEnable), .pcSelBranch(pcSelBranch),
    .regWrite(regWrite), .state(state), .retired(retired), .fault(fault));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Which step of the instruction follows, in terms of the instruction's class and memory progress.
  function automatic int nextOf(int st, int cls, int stall);
    bit stuck = !memReady && stall >= MT - 1;
    int boundary = run ? 1 : 0;
    case (st)
      0: return boundary;
      1: return memReady ? 2 : stuck ? 7 : 1;
      2: return isHalt ? 6 : 3;
      3: return cls == 0 ? 5 : cls == 3 ? boundary : 4;
      4: return memReady ? (cls == 1 ? 5 : boundary) : stuck ? 7 : 4;
      5: return boundary;
      default: return st;
    endcase
  endfunction

  function automatic bit retiresNow(int st, int cls);
    return (st == 3 && cls == 3) || (st == 4 && cls == 2 && memReady) || st == 5;
  endfunction

  // {memReq,memWrite,irEnable,operandEnable,aluOutEnable,mdrEnable,pcEnable,pcSelBranch,regWrite,fault}
  function automatic logic [9:0] expOut(int st, int cls);
    bit fetchDone = st == 1 && memReady;
    bit takeBr = st == 3 && cls == 3 && branchTaken;
    return {st == 1 || st == 4, st == 4 && cls == 2, fetchDone, st == 2, st == 3,
            st == 4 && cls == 1 && memReady, fetchDone || takeBr, takeBr, st == 5, st == 7};
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int st;
    st = mState;
    if (reset) begin
      mState = 0; mCls = 0; mStall = 0; mRet = 0;
    end else begin
      mState = nextOf(st, mCls, mStall);
      if (retiresNow(st, mCls)) mRet = (mRet + 1) % (1 << RW);
      mStall = ((st == 1 || st == 4) && !memReady) ? mStall + 1 : 0;
      if (st == 2) mCls = opClass;
    end
  end

  always @(negedge clk) begin
    chk("model_state", state, mState);
    chk("model_retired", retired, mRet);
    chk("model_outputs", {memReq, memWrite, irEnable, operandEnable, aluOutEnable, mdrEnable,
                          pcEnable, pcSelBranch, regWrite, fault}, expOut(mState, mCls));
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_state", state, 0);
    chk("rst_retired", retired, 0);
    chk("rst_memReq", memReq, 0);
    // ALU, zero wait
    run = 1; memReady = 1; opClass = 0;
    step(); chk("alu_fetch", state, 1); chk("alu_irEnable", irEnable, 1); chk("alu_pcEnable", pcEnable, 1);
    step(); chk("alu_decode", state, 2); chk("alu_operandEnable", operandEnable, 1);
    step(); chk("alu_execute", state, 3); chk("alu_aluOutEnable", aluOutEnable, 1);
    step(); chk("alu_wb", state, 5); chk("alu_regWrite", regWrite, 1); chk("alu_ret_pre", retired, 0);
    step(); chk("alu_fetch2", state, 1); chk("alu_regWrite_off", regWrite, 0); chk("alu_retired", retired, 1);
    // LOAD with three wait cycles in MEMORY; the fourth cycle sits at the watchdog limit
    opClass = 1;
    step(); chk("ld_decode", state, 2);
    memReady = 0;
    step(); chk("ld_execute", state, 3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ld_wait_state", state, 4); chk("ld_memReq", memReq, 1);
      chk("ld_memWrite", memWrite, 0); chk("ld_mdr_early", mdrEnable, 0);
    end
    step(); memReady = 1; #1;
    chk("ld_last_state", state, 4); chk("ld_mdrEnable", mdrEnable, 1); chk("ld_memReq4", memReq, 1);
    step(); chk("ld_wb", state, 5); chk("ld_regWrite", regWrite, 1);
    step(); chk("ld_fetch", state, 1); chk("ld_retired", retired, 2);
    // BRANCH taken, run kept high
    opClass = 3; branchTaken = 1;
    step(); chk("brt_decode", state, 2);
    step(); chk("brt_execute", state, 3); chk("brt_pcEnable", pcEnable, 1);
    chk("brt_pcSel", pcSelBranch, 1); chk("brt_regWrite", regWrite, 0);
    step(); chk("brt_fetch", state, 1); chk("brt_retired", retired, 3);
    // BRANCH not taken, run dropped -> IDLE
    branchTaken = 0; run = 0;
    step(); chk("brn_decode", state, 2);
    step(); chk("brn_execute", state, 3); chk("brn_pcEnable", pcEnable, 0); chk("brn_pcSel", pcSelBranch, 0);
    step(); chk("brn_idle", state, 0); chk("brn_retired", retired, 4);
    step(); chk("idle_hold", state, 0);
    // HALT
    run = 1; isHalt = 1; opClass = 0;
    step(); chk("halt_fetch", state, 1);
    step(); chk("halt_decode", state, 2); chk("halt_operandEnable", operandEnable, 1);
    step(); chk("halt_state", state, 6); chk("halt_retired", retired, 4);
    chk("halt_memReq", memReq, 0); chk("halt_operandEnable_off", operandEnable, 0);
    step(); step(); chk("halt_stays", state, 6);
    #2 reset = 1; #1;
    chk("halt_async_reset", state, 0); chk("halt_reset_retired", retired, 0);
    step(); reset = 0; isHalt = 0;
    // async reset in the middle of a STORE access
    memReady = 1; opClass = 2;
    step(); step(); memReady = 0;
    step(); step();
    chk("st_mem_state", state, 4); chk("st_memReq", memReq, 1); chk("st_memWrite", memWrite, 1);
    #2 reset = 1; #1;
    chk("st_reset_memReq", memReq, 0); chk("st_reset_state", state, 0); chk("st_reset_retired", retired, 0);
    step(); reset = 0;
    // FETCH watchdog expires after four not-ready cycles
    step(); chk("to_fetch1", state, 1);
    step(); step(); step(); chk("to_fetch4", state, 1);
    step(); chk("to_fault", state, 7); chk("to_fault_flag", fault, 1); chk("to_memReq", memReq, 0);
    step(); chk("to_fault_stays", state, 7);
    reset = 1; #1; chk("to_reset_fault", fault, 0);
    step(); reset = 0;
    // ready on the fourth FETCH cycle wins over the watchdog
    step(); step(); step(); step(); memReady = 1; #1;
    chk("rw_fetch4", state, 1); chk("rw_irEnable", irEnable, 1);
    step(); chk("rw_decode", state, 2);
    // STORE stream: retired wraps 15 -> 0, run dropped during the 16th
    opClass = 2;
    step(); step(); step(); chk("wr_first", retired, 1);
    for (int i = 0; i < 14; i++) begin
      step(); step(); step(); step();
    end
    chk("wr_fifteen", retired, 15); chk("wr_fetch", state, 1);
    step(); run = 0;
    step(); step(); chk("wr_store_mem", state, 4);
    step(); chk("wr_wrapped", retired, 0); chk("wr_idle", state, 0);
    step(); chk("wr_idle_hold", state, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
